// File: rtl/id_stage_pipe.sv
// RV32I decode stage with valid/ready handshakes, prioritised operand forwarding and load-use bubbles.
// Optional macro ID_ILLEGAL_TRAP_EN adds the registered illegal_o flag for undecodable encodings.
module id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int FWD_N = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [31:0]             inst_i,
    output logic [4:0]              reg1_addr_o,
    output logic [4:0]              reg2_addr_o,
    input  logic [XLEN-1:0]         reg1_data_i,
    input  logic [XLEN-1:0]         reg2_data_i,
    input  logic [FWD_N-1:0]        fwd_wreg_i,
    input  logic [5*FWD_N-1:0]      fwd_wd_i,
    input  logic [XLEN*FWD_N-1:0]   fwd_wdata_i,
    input  logic                    ex_is_load_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [7:0]              aluop_o,
    output logic [2:0]              alusel_o,
    output logic [XLEN-1:0]         reg1_o,
    output logic [XLEN-1:0]         reg2_o,
    output logic [XLEN-1:0]         store_data_o,
    output logic [4:0]              wd_o,
    output logic                    wreg_o,
    output logic [XLEN-1:0]         link_pc_o,
    output logic [XLEN-1:0]         branch_offset_o,
`ifdef ID_ILLEGAL_TRAP_EN
    output logic                    illegal_o,
`endif
    output logic [CNT_W-1:0]        stall_cnt_o
);

    localparam logic [7:0] EXE_NOP_OP  = 8'd0,  EXE_ADD_OP  = 8'd1,  EXE_SUB_OP  = 8'd2,
                           EXE_SLL_OP  = 8'd3,  EXE_SLT_OP  = 8'd4,  EXE_SLTU_OP = 8'd5,
                           EXE_XOR_OP  = 8'd6,  EXE_SRL_OP  = 8'd7,  EXE_SRA_OP  = 8'd8,
                           EXE_OR_OP   = 8'd9,  EXE_AND_OP  = 8'd10, EXE_JAL_OP  = 8'd11,
                           EXE_JALR_OP = 8'd12, EXE_BEQ_OP  = 8'd13, EXE_BNE_OP  = 8'd14,
                           EXE_BLT_OP  = 8'd15, EXE_BGE_OP  = 8'd16, EXE_BLTU_OP = 8'd17,
                           EXE_BGEU_OP = 8'd18, EXE_LB_OP   = 8'd19, EXE_LH_OP   = 8'd20,
                           EXE_LW_OP   = 8'd21, EXE_LBU_OP  = 8'd22, EXE_LHU_OP  = 8'd23,
                           EXE_SB_OP   = 8'd24, EXE_SH_OP   = 8'd25, EXE_SW_OP   = 8'd26;
    localparam logic [2:0] EXE_RES_NOP   = 3'd0, EXE_RES_LOGIC  = 3'd1, EXE_RES_SHIFT = 3'd2,
                           EXE_RES_ARITH = 3'd3, EXE_RES_JUMP   = 3'd4, EXE_RES_BRANCH = 3'd5,
                           EXE_RES_LOAD  = 3'd6, EXE_RES_STORE  = 3'd7;
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL   = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP   = 7'b0110011;

    // All-zero decode equals the NOP bundle, so an illegal encoding simply clears it.
    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        wreg;
        logic        rs1_used;
        logic        rs2_used;
        logic        use_imm;
        logic        reg1_pc;
        logic        link;
        logic [31:0] imm;
        logic [31:0] boff;
    } dec_t;

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]             rs,
        input logic [XLEN-1:0]        rf_data,
        input logic [FWD_N-1:0]       wreg,
        input logic [5*FWD_N-1:0]     wd,
        input logic [XLEN*FWD_N-1:0]  wdata
    );
        logic [XLEN-1:0] res;
        res = rf_data;
        // Walk oldest to youngest so the lowest matching index wins.
        for (int k = FWD_N - 1; k >= 0; k--) begin
            res = (wreg[k] && (wd[5*k +: 5] == rs)) ? wdata[XLEN*k +: XLEN] : res;
        end
        return (rs == 5'd0) ? {XLEN{1'b0}} : res;
    endfunction

    state_t            state_r;
    dec_t              raw_s;
    dec_t              dec_s;
    logic              illegal_s;
    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic [6:0]        funct7_s;
    logic [4:0]        rs1_s, rs2_s, rd_s, wd0_s;
    logic [31:0]       imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, shamt_s;
    logic [XLEN-1:0]   rs1_val_s, rs2_val_s, reg1_d_s, reg2_d_s, store_d_s;
    logic              hazard_s, accept_s, stall_evt_s;

    assign opcode_s = inst_i[6:0];
    assign funct3_s = inst_i[14:12];
    assign funct7_s = inst_i[31:25];
    assign rd_s     = inst_i[11:7];
    assign rs1_s    = inst_i[19:15];
    assign rs2_s    = inst_i[24:20];
    assign reg1_addr_o = rs1_s;
    assign reg2_addr_o = rs2_s;

    assign imm_i_s = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b_s = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u_s = {inst_i[31:12], 12'd0};
    assign imm_j_s = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign shamt_s = {27'd0, inst_i[24:20]};

    // Instruction decode into a raw bundle plus an illegal-encoding flag.
    always_comb begin
        raw_s     = '0;
        illegal_s = 1'b0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: begin
                raw_s.aluop   = EXE_ADD_OP;
                raw_s.alusel  = EXE_RES_ARITH;
                raw_s.wreg    = 1'b1;
                raw_s.use_imm = 1'b1;
                raw_s.imm     = imm_u_s;
                raw_s.reg1_pc = (opcode_s == OPC_AUIPC);
            end
            OPC_JAL: begin
                raw_s.aluop  = EXE_JAL_OP;
                raw_s.alusel = EXE_RES_JUMP;
                raw_s.wreg   = 1'b1;
                raw_s.link   = 1'b1;
                raw_s.boff   = imm_j_s;
            end
            OPC_JALR: begin
                raw_s.aluop    = EXE_JALR_OP;
                raw_s.alusel   = EXE_RES_JUMP;
                raw_s.wreg     = 1'b1;
                raw_s.rs1_used = 1'b1;
                raw_s.use_imm  = 1'b1;
                raw_s.imm      = imm_i_s;
                raw_s.link     = 1'b1;
                illegal_s      = (funct3_s != 3'd0);
            end
            OPC_BRANCH: begin
                raw_s.alusel   = EXE_RES_BRANCH;
                raw_s.rs1_used = 1'b1;
                raw_s.rs2_used = 1'b1;
                raw_s.boff     = imm_b_s;
                case (funct3_s)
                    3'd0:    raw_s.aluop = EXE_BEQ_OP;
                    3'd1:    raw_s.aluop = EXE_BNE_OP;
                    3'd4:    raw_s.aluop = EXE_BLT_OP;
                    3'd5:    raw_s.aluop = EXE_BGE_OP;
                    3'd6:    raw_s.aluop = EXE_BLTU_OP;
                    3'd7:    raw_s.aluop = EXE_BGEU_OP;
                    default: illegal_s   = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                raw_s.alusel   = EXE_RES_LOAD;
                raw_s.rs1_used = 1'b1;
                raw_s.wreg     = 1'b1;
                raw_s.use_imm  = 1'b1;
                raw_s.imm      = imm_i_s;
                case (funct3_s)
                    3'd0:    raw_s.aluop = EXE_LB_OP;
                    3'd1:    raw_s.aluop = EXE_LH_OP;
                    3'd2:    raw_s.aluop = EXE_LW_OP;
                    3'd4:    raw_s.aluop = EXE_LBU_OP;
                    3'd5:    raw_s.aluop = EXE_LHU_OP;
                    default: illegal_s   = 1'b1;
                endcase
            end
            OPC_STORE: begin
                raw_s.alusel   = EXE_RES_STORE;
                raw_s.rs1_used = 1'b1;
                raw_s.rs2_used = 1'b1;
                raw_s.use_imm  = 1'b1;
                raw_s.imm      = imm_s_s;
                case (funct3_s)
                    3'd0:    raw_s.aluop = EXE_SB_OP;
                    3'd1:    raw_s.aluop = EXE_SH_OP;
                    3'd2:    raw_s.aluop = EXE_SW_OP;
                    default: illegal_s   = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                raw_s.rs1_used = 1'b1;
                raw_s.wreg     = 1'b1;
                raw_s.use_imm  = 1'b1;
                raw_s.imm      = imm_i_s;
                case (funct3_s)
                    3'd0: begin raw_s.aluop = EXE_ADD_OP;  raw_s.alusel = EXE_RES_ARITH; end
                    3'd2: begin raw_s.aluop = EXE_SLT_OP;  raw_s.alusel = EXE_RES_ARITH; end
                    3'd3: begin raw_s.aluop = EXE_SLTU_OP; raw_s.alusel = EXE_RES_ARITH; end
                    3'd4: begin raw_s.aluop = EXE_XOR_OP;  raw_s.alusel = EXE_RES_LOGIC; end
                    3'd6: begin raw_s.aluop = EXE_OR_OP;   raw_s.alusel = EXE_RES_LOGIC; end
                    3'd7: begin raw_s.aluop = EXE_AND_OP;  raw_s.alusel = EXE_RES_LOGIC; end
                    3'd1: begin
                        raw_s.aluop  = EXE_SLL_OP;
                        raw_s.alusel = EXE_RES_SHIFT;
                        raw_s.imm    = shamt_s;
                        illegal_s    = (funct7_s != 7'h00);
                    end
                    3'd5: begin
                        raw_s.aluop  = funct7_s[5] ? EXE_SRA_OP : EXE_SRL_OP;
                        raw_s.alusel = EXE_RES_SHIFT;
                        raw_s.imm    = shamt_s;
                        illegal_s    = (funct7_s != 7'h00) && (funct7_s != 7'h20);
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_OP: begin
                raw_s.rs1_used = 1'b1;
                raw_s.rs2_used = 1'b1;
                raw_s.wreg     = 1'b1;
                // funct7=0x20 is only meaningful for SUB and SRA.
                illegal_s = !((funct7_s == 7'h00) ||
                              ((funct7_s == 7'h20) && ((funct3_s == 3'd0) || (funct3_s == 3'd5))));
                case (funct3_s)
                    3'd0: begin raw_s.aluop = funct7_s[5] ? EXE_SUB_OP : EXE_ADD_OP; raw_s.alusel = EXE_RES_ARITH; end
                    3'd1: begin raw_s.aluop = EXE_SLL_OP;  raw_s.alusel = EXE_RES_SHIFT; end
                    3'd2: begin raw_s.aluop = EXE_SLT_OP;  raw_s.alusel = EXE_RES_ARITH; end
                    3'd3: begin raw_s.aluop = EXE_SLTU_OP; raw_s.alusel = EXE_RES_ARITH; end
                    3'd4: begin raw_s.aluop = EXE_XOR_OP;  raw_s.alusel = EXE_RES_LOGIC; end
                    3'd5: begin raw_s.aluop = funct7_s[5] ? EXE_SRA_OP : EXE_SRL_OP; raw_s.alusel = EXE_RES_SHIFT; end
                    3'd6: begin raw_s.aluop = EXE_OR_OP;   raw_s.alusel = EXE_RES_LOGIC; end
                    3'd7: begin raw_s.aluop = EXE_AND_OP;  raw_s.alusel = EXE_RES_LOGIC; end
                    default: illegal_s = 1'b1;
                endcase
            end
            default: illegal_s = 1'b1;
        endcase
    end

    assign dec_s     = illegal_s ? dec_t'('0) : raw_s;
    assign rs1_val_s = fwd_sel(rs1_s, reg1_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
    assign rs2_val_s = fwd_sel(rs2_s, reg2_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
    assign reg1_d_s  = dec_s.reg1_pc  ? pc_i : (dec_s.rs1_used ? rs1_val_s : {XLEN{1'b0}});
    assign reg2_d_s  = dec_s.use_imm  ? XLEN'($signed(dec_s.imm))
                                      : (dec_s.rs2_used ? rs2_val_s : {XLEN{1'b0}});
    assign store_d_s = dec_s.rs2_used ? rs2_val_s : {XLEN{1'b0}};

    // A load in EX cannot forward yet, so a dependent instruction must wait one cycle.
    assign wd0_s       = fwd_wd_i[4:0];
    assign hazard_s    = ex_is_load_i && fwd_wreg_i[0] && (wd0_s != 5'd0) &&
                         ((dec_s.rs1_used && (rs1_s == wd0_s)) || (dec_s.rs2_used && (rs2_s == wd0_s)));
    assign out_valid_o = (state_r == ST_FULL);
    assign in_ready_o  = !hazard_s && !flush_i && (!out_valid_o || out_ready_i);
    assign accept_s    = in_valid_i && in_ready_o;
    assign stall_evt_s = in_valid_i && hazard_s && !flush_i && out_ready_i;

    // Output state machine, bundle registers and saturating bubble counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_EMPTY;
            aluop_o         <= EXE_NOP_OP;
            alusel_o        <= EXE_RES_NOP;
            reg1_o          <= {XLEN{1'b0}};
            reg2_o          <= {XLEN{1'b0}};
            store_data_o    <= {XLEN{1'b0}};
            wd_o            <= 5'd0;
            wreg_o          <= 1'b0;
            link_pc_o       <= {XLEN{1'b0}};
            branch_offset_o <= {XLEN{1'b0}};
`ifdef ID_ILLEGAL_TRAP_EN
            illegal_o       <= 1'b0;
`endif
            stall_cnt_o     <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1'b1);
            end
            if (flush_i) begin
                state_r <= ST_EMPTY;
            end else if (accept_s) begin
                state_r         <= ST_FULL;
                aluop_o         <= dec_s.aluop;
                alusel_o        <= dec_s.alusel;
                reg1_o          <= reg1_d_s;
                reg2_o          <= reg2_d_s;
                store_data_o    <= store_d_s;
                wd_o            <= dec_s.wreg ? rd_s : 5'd0;
                wreg_o          <= dec_s.wreg;
                link_pc_o       <= dec_s.link ? (pc_i + XLEN'(32'd4)) : {XLEN{1'b0}};
                branch_offset_o <= XLEN'($signed(dec_s.boff));
`ifdef ID_ILLEGAL_TRAP_EN
                illegal_o       <= illegal_s;
`endif
            end else if (out_ready_i) begin
                state_r <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed-vector bench for id_stage_pipe: decode, forwarding priority, load-use bubbles,
// back-pressure hold, flush, async reset and stall-counter saturation (CNT_W=2).
module tb_id_stage_pipe;

    localparam logic [7:0] OP_NOP = 8'd0, OP_ADD = 8'd1, OP_SUB = 8'd2, OP_SLTU = 8'd5,
                           OP_JAL = 8'd11, OP_BEQ = 8'd13;
    localparam logic [2:0] SEL_NOP = 3'd0, SEL_ARITH = 3'd3, SEL_JUMP = 3'd4, SEL_BRANCH = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, ex_is_load, flush, out_valid, out_ready, wreg;
    logic [31:0] pc, inst, reg1_data, reg2_data, reg1, reg2, store_data, link_pc, boff;
    logic [4:0]  reg1_addr, reg2_addr, wd;
    logic [1:0]  fwd_wreg;
    logic [9:0]  fwd_wd;
    logic [63:0] fwd_wdata;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [1:0]  stall_cnt;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int checks = 0;
    int errors = 0;

    id_stage_pipe #(.XLEN(32), .FWD_N(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .inst_i(inst), .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
        .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
        .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata),
        .ex_is_load_i(ex_is_load), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .aluop_o(aluop), .alusel_o(alusel), .reg1_o(reg1), .reg2_o(reg2),
        .store_data_o(store_data), .wd_o(wd), .wreg_o(wreg), .link_pc_o(link_pc),
        .branch_offset_o(boff),
`ifdef ID_ILLEGAL_TRAP_EN
        .illegal_o(illegal),
`endif
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ex_is_load = 1'b0; flush = 1'b0;
        pc = 32'h100; inst = 32'h0; reg1_data = 32'h0; reg2_data = 32'h0;
        fwd_wreg = 2'b00; fwd_wd = 10'd0; fwd_wdata = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_aluop", aluop, OP_NOP);
        check("rst_alusel", alusel, SEL_NOP);
        check("rst_reg2", reg2, 0);
        check("rst_stall", stall_cnt, 0);
        rst = 1'b1;

        // T1 addi x1,x0,5
        in_valid = 1'b1; inst = 32'h0050_0093; #1;
        check("t1_ready", in_ready, 1);
        check("t1_raddr1", reg1_addr, 0);
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_aluop", aluop, OP_ADD);
        check("t1_alusel", alusel, SEL_ARITH);
        check("t1_reg1", reg1, 0);
        check("t1_reg2", reg2, 5);
        check("t1_wd", wd, 1);
        check("t1_wreg", wreg, 1);

        // T2 add x3,x1,x2 with forwarding priority
        inst = 32'h0020_81B3; reg1_data = 32'h11; reg2_data = 32'h22;
        fwd_wreg = 2'b11; fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'd9, 32'd7}; #1;
        check("t2_raddr2", reg2_addr, 2);
        tick();
        check("t2a_reg1", reg1, 7);
        check("t2a_reg2", reg2, 32'h22);
        check("t2a_wd", wd, 3);
        fwd_wd = {5'd2, 5'd1}; fwd_wdata = {32'd4, 32'd7};
        tick();
        check("t2b_reg1", reg1, 7);
        check("t2b_reg2", reg2, 4);
        check("t2b_store", store_data, 4);

        // T3 load-use on rs1=x5: addi x6,x5,1
        inst = 32'h0012_8313; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd5}; fwd_wdata = {32'd0, 32'h55};
        ex_is_load = 1'b1; #1;
        check("t3_ready_haz", in_ready, 0);
        tick();
        check("t3_bubble", out_valid, 0);
        check("t3_stall", stall_cnt, 1);
        ex_is_load = 1'b0; #1;
        check("t3_ready", in_ready, 1);
        tick();
        check("t3_valid", out_valid, 1);
        check("t3_reg1", reg1, 32'h55);
        check("t3_reg2", reg2, 1);
        check("t3_stall_keep", stall_cnt, 1);

        // T4 sub x8,x2,x1 then back-pressure for 3 cycles
        inst = 32'h4011_0433; fwd_wreg = 2'b00; reg1_data = 32'h30; reg2_data = 32'h10;
        tick();
        check("t4_aluop", aluop, OP_SUB);
        check("t4_reg1", reg1, 32'h30);
        check("t4_reg2", reg2, 32'h10);
        out_ready = 1'b0; inst = 32'h0050_0093;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_hold_ready", in_ready, 0);
            @(posedge clk); #1;
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_aluop", aluop, OP_SUB);
            check("t4_hold_reg1", reg1, 32'h30);
        end
        out_ready = 1'b1; #1;
        check("t4_drain_ready", in_ready, 1);
        tick();
        check("t4_next_aluop", aluop, OP_ADD);
        check("t4_next_reg2", reg2, 5);

        // Async reset while holding a bundle
        out_ready = 1'b0; inst = 32'h4011_0433;
        tick();
        check("t6_pre_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_aluop", aluop, OP_NOP);
        check("t6_rst_reg2", reg2, 0);
        check("t6_rst_wreg", wreg, 0);
        #1 rst = 1'b1;

        // T5 flush during hazard
        out_ready = 1'b1; inst = 32'h0050_0093;
        tick();
        check("t5_fill", out_valid, 1);
        inst = 32'h0012_8313; ex_is_load = 1'b1; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd5};
        flush = 1'b1; #1;
        check("t5_haz_ready", in_ready, 0);
        tick();
        check("t5_haz_valid", out_valid, 0);
        check("t5_haz_stall", stall_cnt, 0);
        flush = 1'b0; ex_is_load = 1'b0; fwd_wreg = 2'b00;

        // T5 flush during hold
        inst = 32'h0050_0093;
        tick();
        out_ready = 1'b0; inst = 32'h4011_0433; flush = 1'b1; #1;
        check("t5_hold_ready", in_ready, 0);
        tick();
        check("t5_hold_valid", out_valid, 0);
        flush = 1'b0; out_ready = 1'b1;

        // T5 addi x9,x0,3 with a source targeting x0
        inst = 32'h0030_0493; ex_is_load = 1'b1; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd0};
        fwd_wdata = {32'd0, 32'hFFFF}; #1;
        check("t5_x0_ready", in_ready, 1);
        tick();
        check("t5_x0_valid", out_valid, 1);
        check("t5_x0_reg1", reg1, 0);
        check("t5_x0_reg2", reg2, 3);
        ex_is_load = 1'b0; fwd_wreg = 2'b00;

        // jal x1,+8
        pc = 32'h200; inst = 32'h0080_00EF;
        tick();
        check("jal_aluop", aluop, OP_JAL);
        check("jal_alusel", alusel, SEL_JUMP);
        check("jal_link", link_pc, 32'h204);
        check("jal_boff", boff, 8);
        check("jal_wd", wd, 1);

        // beq x1,x2,-4
        inst = 32'hFE20_8EE3;
        tick();
        check("beq_aluop", aluop, OP_BEQ);
        check("beq_alusel", alusel, SEL_BRANCH);
        check("beq_wreg", wreg, 0);
        check("beq_boff", boff, 32'hFFFF_FFFC);
        check("beq_store", store_data, 32'h10);
        check("beq_link", link_pc, 0);

        // sltiu x1,x2,-1: immediate is sign-extended
        inst = 32'hFFF1_3093;
        tick();
        check("sltiu_aluop", aluop, OP_SLTU);
        check("sltiu_reg2", reg2, 32'hFFFF_FFFF);
        check("sltiu_reg1", reg1, 32'h30);
`ifdef ID_ILLEGAL_TRAP_EN
        check("sltiu_illegal", illegal, 0);
`endif

        // T6 undecodable word
        inst = 32'hFFFF_FFFF;
        tick();
        check("t6_ill_valid", out_valid, 1);
        check("t6_ill_wreg", wreg, 0);
        check("t6_ill_aluop", aluop, OP_NOP);
`ifdef ID_ILLEGAL_TRAP_EN
        check("t6_ill_flag", illegal, 1);
`endif

        // Repeated load-use bubbles saturate the 2-bit counter at 3
        inst = 32'h0012_8313; ex_is_load = 1'b1; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd5};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_valid", out_valid, 0);
            check("sat_stall", stall_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        in_valid = 1'b0; ex_is_load = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
